fcmp_pipe: RTL and testbench

//  Pipelined, parametrised FP compare/select unit for the FPU issue path; successor to the

---
 rtl/fpu_pkg.sv | 40 ++++
 rtl/fcmp_core.sv | 86 ++++++++
 rtl/fcmp_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_fcmp_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
//   Shared types and helpers for the FP compare/select pipeline.
//   - fcmp_op_e   : operation encoding carried on in_op (5..7 are reserved)
//   - fp_class_e  : operand classification produced by fcmp_core
//   - canon_qnan  : canonical quiet NaN {0, all-ones exponent, 1, zeros}
//                   for a given exponent/mantissa width. It is returned
//                   right-aligned in an FP_MAX_W-bit vector; callers slice it.
// ---------------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    NORM = 3'd1,
    INF  = 3'd2,
    QNAN = 3'd3,
    SNAN = 3'd4
  } fp_class_e;

  localparam int FP_MAX_W    = 128;
  // eq, lt, x1_nan, x2_nan, snan_any
  localparam int FCMP_FLAG_W = 5;

  // exp_w+1 ones (exponent plus the quiet bit), shifted so the quiet bit
  // lands on the mantissa MSB.
  function automatic logic [FP_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] ones;
    ones = (FP_MAX_W'(1) << (exp_w + 1)) - FP_MAX_W'(1);
    return ones << (man_w - 1);
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// ---------------------------------------------------------------------------
// fcmp_core
//   Purely combinational classify + compare for two IEEE-style operands.
//   Denormals are flushed: any operand with a zero exponent is treated as
//   zero, and +0 == -0.
//   Optional feature: FCMP_NAN_EN (exp all-ones & man != 0 is a NaN; any NaN
//   forces eq/lt low). Without it, all-ones exponents order as ordinary
//   magnitudes and the NaN outputs stay low.
// Ports
//   x1_i, x2_i   in  W  operands
//   eq_o         out 1  x1 == x2 (ordered, NaN-free)
//   lt_o         out 1  x1 <  x2 (ordered, NaN-free)
//   x1_nan_o     out 1  x1 is a NaN
//   x2_nan_o     out 1  x2 is a NaN
//   snan_o       out 1  at least one operand is a signalling NaN
// ---------------------------------------------------------------------------
module fcmp_core
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
  output logic         eq_o,
  output logic         lt_o,
  output logic         x1_nan_o,
  output logic         x2_nan_o,
  output logic         snan_o
);

  // Classification from the magnitude bits {exp, man}.
  function automatic fp_class_e classify(input logic [W-2:0] mag);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = mag[W-2 -: EXP_W];
    m = mag[MAN_W-1:0];
    if (e == '0) return ZERO;
    if (&e) begin
`ifdef FCMP_NAN_EN
      if (m == '0) return INF;
      return m[MAN_W-1] ? QNAN : SNAN;
`else
      return (m == '0) ? INF : NORM;
`endif
    end
    return NORM;
  endfunction

  fp_class_e  cls1, cls2;
  logic       z1, z2;
  logic       nan_any;
  logic       s1_eff, s2_eff;
  logic [W-2:0] m1_eff, m2_eff;
  logic       eq_ord, lt_ord;

  always_comb begin
    cls1 = classify(x1_i[W-2:0]);
    cls2 = classify(x2_i[W-2:0]);
    z1   = (cls1 == ZERO);
    z2   = (cls2 == ZERO);

    x1_nan_o = (cls1 == QNAN) | (cls1 == SNAN);
    x2_nan_o = (cls2 == QNAN) | (cls2 == SNAN);
    snan_o   = (cls1 == SNAN) | (cls2 == SNAN);
    nan_any  = x1_nan_o | x2_nan_o;

    // A zero collapses to sign 0 / magnitude 0 so both zeros share one key.
    s1_eff = x1_i[W-1] & ~z1;
    s2_eff = x2_i[W-1] & ~z2;
    m1_eff = z1 ? '0 : x1_i[W-2:0];
    m2_eff = z2 ? '0 : x2_i[W-2:0];

    eq_ord = (z1 & z2) | (x1_i == x2_i);

    // Sign first; among negatives the larger magnitude is the smaller value.
    if (s1_eff != s2_eff) lt_ord = s1_eff;
    else if (!s1_eff)     lt_ord = (m1_eff < m2_eff);
    else                  lt_ord = (m1_eff > m2_eff);

    eq_o = eq_ord & ~nan_any;
    lt_o = lt_ord & ~nan_any;
  end

endmodule

// File: rtl/fcmp_pipe.sv
// ---------------------------------------------------------------------------
// fcmp_pipe
//   Elastic, STAGES-deep (1..3) FP compare/select pipeline: FEQ, FLT, FLE,
//   FMIN, FMAX on W = 1+EXP_W+MAN_W bit operands. Classification and compare
//   happen in stage 0 (fcmp_core); select/format happens when the last stage
//   loads. With STAGES == 1 both happen in front of the single stage.
//   Optional feature macro: FCMP_NAN_EN (NaN-aware compare and min/max).
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    operation handshake
//   in_op                3-bit op (0 FEQ,1 FLT,2 FLE,3 FMIN,4 FMAX, 5..7 reserved)
//   in_x1, in_x2         operands (W bits)
//   in_tag               sideband tag, returned unchanged on out_tag
//   out_valid/out_ready  result handshake
//   out_y                compare: {zeros, flag}; min/max: chosen operand bits
//   out_tag              tag of the result
//   out_inv              invalid flag
// ---------------------------------------------------------------------------
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter  int EXP_W  = 8,
  parameter  int MAN_W  = 23,
  parameter  int STAGES = 2,
  parameter  int TAG_W  = 5,
  localparam int W      = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [W-1:0]     in_x1,
  input  logic [W-1:0]     in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inv
);

  // Handshake: a transfer happens on every rising edge where valid and ready
  // are both high. valid never depends on ready; once out_valid is high it
  // stays high with out_y/out_tag/out_inv unchanged until out_ready takes it.
  // A stage loads when it is empty or when it hands its content on in the
  // same cycle, so bubbles collapse and a full pipeline still takes one op
  // per cycle while the consumer is ready.

  localparam int MID_W = 3 + 2 * W + TAG_W + FCMP_FLAG_W;
  localparam logic [W-1:0] CANON_QNAN = W'(canon_qnan(EXP_W, MAN_W));

  // -------------------------------------------------------------------------
  // Stage-0 compare
  // -------------------------------------------------------------------------
  logic c_eq, c_lt, c_nan1, c_nan2, c_snan;

  fcmp_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_core (
    .x1_i     (in_x1),
    .x2_i     (in_x2),
    .eq_o     (c_eq),
    .lt_o     (c_lt),
    .x1_nan_o (c_nan1),
    .x2_nan_o (c_nan2),
    .snan_o   (c_snan)
  );

  logic [MID_W-1:0] mid_in;
  assign mid_in = {in_op, in_x1, in_x2, in_tag, c_eq, c_lt, c_nan1, c_nan2, c_snan};

  // -------------------------------------------------------------------------
  // Valid bits and load enables
  // -------------------------------------------------------------------------
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] load;

  // Walk from the output backwards: a stage may load if it is empty or the
  // stage after it can take its content this cycle.
  always_comb begin
    logic rdy;
    rdy  = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy     = ~v_q[k] | rdy;
      load[k] = rdy;
    end
  end

  always_comb begin
    v_d = v_q;
    if (load[0]) v_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) v_d[k] = v_q[k-1];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[STAGES-1];

  // -------------------------------------------------------------------------
  // Payload registers between stage 0 and the last stage
  // -------------------------------------------------------------------------
  logic [MID_W-1:0] fmt_src;
  logic             src_v;

  generate
    if (STAGES == 1) begin : g_single
      assign fmt_src = mid_in;
      assign src_v   = in_valid;
    end else begin : g_multi
      logic [MID_W-1:0] mid_q [STAGES-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < STAGES - 1; k++) mid_q[k] <= '0;
        end else begin
          if (load[0] & in_valid) mid_q[0] <= mid_in;
          for (int k = 1; k < STAGES - 1; k++) begin
            if (load[k] & v_q[k-1]) mid_q[k] <= mid_q[k-1];
          end
        end
      end

      assign fmt_src = mid_q[STAGES-2];
      assign src_v   = v_q[STAGES-2];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Select / format
  // -------------------------------------------------------------------------
  logic [2:0]       f_op;
  logic [W-1:0]     f_x1, f_x2;
  logic [TAG_W-1:0] f_tag;
  logic             f_eq, f_lt, f_nan1, f_nan2, f_snan;
  logic [W-1:0]     fmt_y;
  logic             fmt_inv;

  always_comb begin
    {f_op, f_x1, f_x2, f_tag, f_eq, f_lt, f_nan1, f_nan2, f_snan} = fmt_src;
    fmt_y   = '0;
    fmt_inv = 1'b0;
    case (f_op)
      FEQ: begin
        fmt_y[0] = f_eq;
        fmt_inv  = f_snan;          // quiet NaNs compare silently for FEQ
      end
      FLT: begin
        fmt_y[0] = f_lt;
        fmt_inv  = f_nan1 | f_nan2;
      end
      FLE: begin
        fmt_y[0] = f_lt | f_eq;
        fmt_inv  = f_nan1 | f_nan2;
      end
      FMIN, FMAX: begin
        // Original (unflushed) operand bits; ties return x1.
        if (f_nan1 & f_nan2)   fmt_y = CANON_QNAN;
        else if (f_nan1)       fmt_y = f_x2;
        else if (f_nan2)       fmt_y = f_x1;
        else if (f_op == FMIN) fmt_y = (f_lt | f_eq) ? f_x1 : f_x2;
        else                   fmt_y = f_lt ? f_x2 : f_x1;
      end
      default: begin
        fmt_y   = '0;
        fmt_inv = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Last stage: drives out_* directly
  // -------------------------------------------------------------------------
  logic             fin_load;
  logic [W-1:0]     y_q, y_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             inv_q, inv_d;

  assign fin_load = load[STAGES-1] & src_v;

  always_comb begin
    y_d   = fin_load ? fmt_y   : y_q;
    tag_d = fin_load ? f_tag   : tag_q;
    inv_d = fin_load ? fmt_inv : inv_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      y_q   <= '0;
      tag_q <= '0;
      inv_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      y_q   <= y_d;
      tag_q <= tag_d;
      inv_q <= inv_d;
    end
  end

  assign out_y   = y_q;
  assign out_tag = tag_q;
  assign out_inv = inv_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// ---------------------------------------------------------------------------
// tb_fcmp_pipe
//   Directed bench for fcmp_pipe with a table of hand-computed vectors plus
//   hand-written sequences for latency, back-pressure and mid-flight reset.
//   Build with FCMP_NAN_EN defined to exercise the NaN-aware vectors.
// ---------------------------------------------------------------------------
module tb_fcmp_pipe;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int EW     = TAG_W + 1 + W;

  localparam logic [2:0] OP_FEQ  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FLE  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] y;
    logic         inv;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [2:0]       in_op;
  logic [W-1:0]     in_x1, in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [W-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_inv;

  always #5 clk = ~clk;

  fcmp_pipe #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_inv   (out_inv)
  );

  // ---------------- bookkeeping ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [TAG_W-1:0] tag_cnt = '0;
  vec_t             vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void add(input logic [2:0] op, input logic [W-1:0] x1,
                              input logic [W-1:0] x2, input logic [W-1:0] y,
                              input logic inv);
    vec_t v;
    v.op = op; v.x1 = x1; v.x2 = x2; v.y = y; v.inv = inv;
    vecs.push_back(v);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic          was_stall = 1'b0;
  logic [EW-1:0] held, got, e_val;

  always @(negedge clk) begin
    if (rst) begin
      was_stall = 1'b0;
    end else begin
      got = {out_tag, out_inv, out_y};
      if (was_stall) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_result_held", 64'(got), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL retire_unexpected: got 0x%0h, expected no retire", got);
        end else begin
          e_val = exp_q.pop_front();
          check("retire_tag_inv_y", 64'(got), 64'(e_val));
        end
      end
      was_stall = out_valid && !out_ready;
      held      = got;
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input vec_t v);
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    in_op    = v.op;
    in_x1    = v.x1;
    in_x2    = v.x2;
    in_tag   = tag_cnt;
    @(negedge clk);
    while (!in_ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 100 cycles");
    end else begin
      exp_q.push_back({tag_cnt, v.inv, v.y});
    end
    tag_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic lat_check(input vec_t v);
    int cnt;
    send(v);
    in_valid = 1'b0;
    cnt = 1;
    @(negedge clk);
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check("latency_cycles", 64'(cnt), 64'(STAGES));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_y"},     64'(out_y),     64'd0);
    check({tag, "_out_tag"},   64'(out_tag),   64'd0);
    check({tag, "_out_inv"},   64'(out_inv),   64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t lv;

    // Vector table: {op, x1, x2, expected y, expected inv}
    add(OP_FLT,  32'h3F800000, 32'h40000000, 32'h00000001, 1'b0); // 1.0 < 2.0
    add(OP_FLT,  32'h40000000, 32'h3F800000, 32'h00000000, 1'b0);
    add(OP_FEQ,  32'h80000000, 32'h00000000, 32'h00000001, 1'b0); // -0 == +0
    add(OP_FEQ,  32'h00000001, 32'h00000000, 32'h00000001, 1'b0); // denormal flushed
    add(OP_FLE,  32'hBF800000, 32'hC0000000, 32'h00000000, 1'b0); // -1 <= -2 false
    add(OP_FMIN, 32'hBF800000, 32'hC0000000, 32'hC0000000, 1'b0);
    add(OP_FMAX, 32'hBF800000, 32'hC0000000, 32'hBF800000, 1'b0);
    add(OP_FLT,  32'hC0000000, 32'hBF800000, 32'h00000001, 1'b0); // -2 < -1
    add(OP_FLT,  32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    add(OP_FLE,  32'h80000000, 32'h00000000, 32'h00000001, 1'b0);
    add(OP_FMIN, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0); // tie -> x1
    add(OP_FMAX, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0); // tie -> x1 unflushed
    add(OP_FLT,  32'hBF800000, 32'h3F800000, 32'h00000001, 1'b0);
    add(OP_FLT,  32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0);
    add(OP_FEQ,  32'h3F800000, 32'h3F800001, 32'h00000000, 1'b0);
    add(OP_FLT,  32'h80000000, 32'hBF800000, 32'h00000000, 1'b0); // 0 < -1 false
    add(OP_FLT,  32'hBF800000, 32'h00000000, 32'h00000001, 1'b0);
    add(OP_FMAX, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0);
    add(OP_FMIN, 32'h3F800000, 32'h3F800001, 32'h3F800000, 1'b0);
    add(OP_FLT,  32'h00800000, 32'h00000001, 32'h00000000, 1'b0); // min normal vs flushed 0
    add(OP_FLT,  32'h00000001, 32'h00800000, 32'h00000001, 1'b0);
    add(OP_FLE,  32'h3F800000, 32'h7F800000, 32'h00000001, 1'b0); // 1.0 <= inf
    add(3'd7,    32'h3F800000, 32'h40000000, 32'h00000000, 1'b1); // reserved op
    add(3'd5,    32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
`ifdef FCMP_NAN_EN
    add(OP_FLT,  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1);
    add(OP_FMAX, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b0);
    add(OP_FEQ,  32'h7F800001, 32'h3F800000, 32'h00000000, 1'b1); // sNaN
    add(OP_FEQ,  32'h7FC00000, 32'h7FC00000, 32'h00000000, 1'b0); // qNaN quiet
    add(OP_FLE,  32'h3F800000, 32'h7FC00000, 32'h00000000, 1'b1);
    add(OP_FMIN, 32'h7FC00001, 32'h7F800001, 32'h7FC00000, 1'b0); // both NaN -> canonical
    add(OP_FMIN, 32'h3F800000, 32'h7F800001, 32'h3F800000, 1'b0);
`else
    add(OP_FLT,  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0);
    add(OP_FMAX, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0);
    add(OP_FEQ,  32'h7FC00000, 32'h7FC00000, 32'h00000001, 1'b0);
    add(OP_FLT,  32'h3F800000, 32'h7FC00000, 32'h00000001, 1'b0);
    add(OP_FMIN, 32'h7FC00000, 32'h7F800001, 32'h7F800001, 1'b0);
`endif

    // Reset
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_x1     = '0;
    in_x2     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;

    // Latency of a single op into an empty pipeline
    lat_check(vecs[0]);
    drain();

    // Full table, streamed back to back
    foreach (vecs[i]) send(vecs[i]);
    in_valid = 1'b0;
    drain();

    // Back-to-back 8 ops with a 3-cycle consumer stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(vecs[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stream_in_ready_full_flowing", 64'(in_ready), 64'd1);
        check("stream_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight: both are dropped
    send(vecs[5]);
    send(vecs[6]);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    repeat (8) @(negedge clk);
    check("midrst_no_retire", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Pipeline still usable after the reset
    lv = vecs[17];
    lat_check(lv);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
